// File: rtl/sprite_selector.sv
// Sprite selector: per-pixel hit test against double-buffered sprite positions,
// producing the sprite ROM address (stage 1) and the aligned mux select/hit (stage 2).
module sprite_selector #(
  parameter int M     = 2,
  parameter int B     = $clog2(M),
  parameter int SPR_W = 32,
  parameter int SPR_H = 32,
  parameter int AW    = $clog2(SPR_W*SPR_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [9:0]    pixel_x,
  input  logic [9:0]    pixel_y,
  input  logic          video_on,
  input  logic          frame_start,
  input  logic          pos_wr,
  input  logic [B-1:0]  pos_idx,
  input  logic [9:0]    pos_x,
  input  logic [9:0]    pos_y,
  input  logic          pos_en,
  output logic [AW-1:0] rom_addr,
  output logic [B-1:0]  s,
  output logic          hit
);

  localparam int XW = $clog2(SPR_W);
  localparam int YW = AW - XW;

  logic [9:0]    sh_x_q  [M];
  logic [9:0]    sh_y_q  [M];
  logic          sh_en_q [M];
  logic [9:0]    act_x_q [M];
  logic [9:0]    act_y_q [M];
  logic          act_en_q[M];

  logic [AW-1:0] rom_addr_q;
  logic          hit1_q;
  logic [B-1:0]  idx1_q;
  logic [B-1:0]  s_q;
  logic          hit_q;

  logic [M-1:0]  wr_sel;
  logic [M-1:0]  in_hit;
  logic          hit_d;
  logic [B-1:0]  idx_d;
  logic [9:0]    x_win;
  logic [9:0]    y_win;
  logic [XW-1:0] dx;
  logic [YW-1:0] dy;
  logic [AW-1:0] rom_addr_d;

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < M; i++) begin
      wr_sel[i] = pos_wr && (int'(pos_idx) == i);
    end
  end

  // 11-bit bounds so a sprite near the right/bottom edge clips instead of wrapping
  always_comb begin
    in_hit = '0;
    for (int i = 0; i < M; i++) begin
      in_hit[i] = act_en_q[i] & video_on
                & (pixel_x >= act_x_q[i])
                & ({1'b0, pixel_x} < ({1'b0, act_x_q[i]} + 11'(SPR_W)))
                & (pixel_y >= act_y_q[i])
                & ({1'b0, pixel_y} < ({1'b0, act_y_q[i]} + 11'(SPR_H)));
    end
  end

  // Scan downwards so the lowest covering index is the last one kept
  always_comb begin
    hit_d = 1'b0;
    idx_d = '0;
    x_win = '0;
    y_win = '0;
    for (int i = M - 1; i >= 0; i--) begin
      if (in_hit[i]) begin
        hit_d = 1'b1;
        idx_d = B'(i);
        x_win = act_x_q[i];
        y_win = act_y_q[i];
      end
    end
    dx         = XW'(pixel_x - x_win);
    dy         = YW'(pixel_y - y_win);
    rom_addr_d = hit_d ? {dy, dx} : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < M; i++) begin
        sh_x_q[i]   <= '0;
        sh_y_q[i]   <= '0;
        sh_en_q[i]  <= 1'b0;
        act_x_q[i]  <= '0;
        act_y_q[i]  <= '0;
        act_en_q[i] <= 1'b0;
      end
      rom_addr_q <= '0;
      hit1_q     <= 1'b0;
      idx1_q     <= '0;
      s_q        <= '0;
      hit_q      <= 1'b0;
    end else begin
      for (int i = 0; i < M; i++) begin
        if (wr_sel[i]) begin
          sh_x_q[i]  <= pos_x;
          sh_y_q[i]  <= pos_y;
          sh_en_q[i] <= pos_en;
        end
        if (frame_start) begin
          act_x_q[i]  <= wr_sel[i] ? pos_x  : sh_x_q[i];
          act_y_q[i]  <= wr_sel[i] ? pos_y  : sh_y_q[i];
          act_en_q[i] <= wr_sel[i] ? pos_en : sh_en_q[i];
        end
      end
      rom_addr_q <= rom_addr_d;
      hit1_q     <= hit_d;
      idx1_q     <= idx_d;
      s_q        <= hit1_q ? idx1_q : '0;
      hit_q      <= hit1_q;
    end
  end

  assign rom_addr = rom_addr_q;
  assign s        = s_q;
  assign hit      = hit_q;

endmodule

// File: tb/tb_sprite_selector.sv
// Directed self-checking bench for sprite_selector (M=2, 32x32 sprites).
module tb_sprite_selector;

  logic       clk;
  logic       rst;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       video_on;
  logic       frame_start;
  logic       pos_wr;
  logic [0:0] pos_idx;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic       pos_en;
  logic [9:0] rom_addr;
  logic [0:0] s;
  logic       hit;

  int checks;
  int failures;

  sprite_selector dut (
    .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .frame_start(frame_start), .pos_wr(pos_wr),
    .pos_idx(pos_idx), .pos_x(pos_x), .pos_y(pos_y), .pos_en(pos_en),
    .rom_addr(rom_addr), .s(s), .hit(hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic write_pos(input logic [0:0] idx, input int x, input int y,
                           input logic en, input logic fs);
    pos_wr      = 1'b1;
    pos_idx     = idx;
    pos_x       = 10'(x);
    pos_y       = 10'(y);
    pos_en      = en;
    frame_start = fs;
    @(posedge clk); #1;
    pos_wr      = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  // Holds the pixel, captures rom_addr after one edge and s/hit after the second
  task automatic drive_pixel(input int x, input int y, input logic von,
                             output logic [9:0] a, output logic [0:0] sv,
                             output logic h);
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = von;
    @(posedge clk); #1;
    a = rom_addr;
    @(posedge clk); #1;
    sv = s;
    h  = hit;
  endtask

  task automatic test_reset();
    logic [9:0] a; logic [0:0] sv; logic h;
    rst = 1'b1; pixel_x = 10'd123; pixel_y = 10'd77; video_on = 1'b1;
    frame_start = 1'b1; pos_wr = 1'b1; pos_idx = 1'b1;
    pos_x = 10'd120; pos_y = 10'd70; pos_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rom_addr !== 10'd0) begin failures++; $display("FAIL reset_addr: got %0d want 0", rom_addr); end
    checks++;
    if (s !== 1'b0) begin failures++; $display("FAIL reset_s: got %0d want 0", s); end
    checks++;
    if (hit !== 1'b0) begin failures++; $display("FAIL reset_hit: got %0d want 0", hit); end
    rst = 1'b0; frame_start = 1'b0; pos_wr = 1'b0; video_on = 1'b0;
    write_pos(1'b0, 100, 50, 1'b1, 1'b0);
    drive_pixel(100, 50, 1'b1, a, sv, h);
    checks++;
    if (h !== 1'b0) begin failures++; $display("FAIL uncommitted_hit: got %0d want 0", h); end
    checks++;
    if (a !== 10'd0) begin failures++; $display("FAIL uncommitted_addr: got %0d want 0", a); end
  endtask

  task automatic test_commit();
    logic [9:0] a; logic [0:0] sv; logic h;
    write_pos(1'b1, 200, 100, 1'b1, 1'b0);
    frame();
    drive_pixel(205, 103, 1'b1, a, sv, h);
    checks++;
    if (a !== 10'd101) begin failures++; $display("FAIL commit_addr: got %0d want 101", a); end
    checks++;
    if (sv !== 1'b1) begin failures++; $display("FAIL commit_s: got %0d want 1", sv); end
    checks++;
    if (h !== 1'b1) begin failures++; $display("FAIL commit_hit: got %0d want 1", h); end
    drive_pixel(232, 103, 1'b1, a, sv, h);
    checks++;
    if (h !== 1'b0) begin failures++; $display("FAIL right_edge_hit: got %0d want 0", h); end
    checks++;
    if (a !== 10'd0 || sv !== 1'b0) begin
      failures++; $display("FAIL miss_addr_s: got addr=%0d s=%0d want 0/0", a, sv);
    end
    drive_pixel(231, 131, 1'b1, a, sv, h);
    checks++;
    if (h !== 1'b1 || a !== 10'd1023) begin
      failures++; $display("FAIL corner_pixel: got hit=%0d addr=%0d want 1/1023", h, a);
    end
  endtask

  task automatic test_overlap();
    logic [9:0] a; logic [0:0] sv; logic h;
    write_pos(1'b0, 300, 300, 1'b1, 1'b0);
    write_pos(1'b1, 310, 310, 1'b1, 1'b0);
    frame();
    drive_pixel(315, 315, 1'b1, a, sv, h);
    checks++;
    if (sv !== 1'b0 || h !== 1'b1) begin
      failures++; $display("FAIL overlap_s0: got s=%0d hit=%0d want 0/1", sv, h);
    end
    checks++;
    if (a !== 10'd495) begin failures++; $display("FAIL overlap_addr0: got %0d want 495", a); end
    drive_pixel(335, 335, 1'b1, a, sv, h);
    checks++;
    if (sv !== 1'b1 || h !== 1'b1) begin
      failures++; $display("FAIL overlap_s1: got s=%0d hit=%0d want 1/1", sv, h);
    end
    checks++;
    if (a !== 10'd825) begin failures++; $display("FAIL overlap_addr1: got %0d want 825", a); end
    write_pos(1'b1, 300, 300, 1'b1, 1'b1);
    drive_pixel(302, 304, 1'b1, a, sv, h);
    checks++;
    if (sv !== 1'b0 || h !== 1'b1 || a !== 10'd130) begin
      failures++; $display("FAIL equal_pos: got s=%0d hit=%0d addr=%0d want 0/1/130", sv, h, a);
    end
  endtask

  task automatic test_edge_clip();
    logic [9:0] a; logic [0:0] sv; logic h;
    write_pos(1'b0, 630, 470, 1'b1, 1'b0);
    write_pos(1'b1, 310, 310, 1'b0, 1'b1);
    drive_pixel(639, 479, 1'b1, a, sv, h);
    checks++;
    if (h !== 1'b1 || sv !== 1'b0) begin
      failures++; $display("FAIL clip_hit: got hit=%0d s=%0d want 1/0", h, sv);
    end
    checks++;
    if (a !== 10'd297) begin failures++; $display("FAIL clip_addr: got %0d want 297", a); end
    drive_pixel(0, 470, 1'b1, a, sv, h);
    checks++;
    if (h !== 1'b0) begin failures++; $display("FAIL no_wrap: got %0d want 0", h); end
  endtask

  task automatic test_collision();
    logic [9:0] a; logic [0:0] sv; logic h;
    write_pos(1'b0, 10, 10, 1'b1, 1'b1);
    drive_pixel(10, 10, 1'b1, a, sv, h);
    checks++;
    if (h !== 1'b1 || a !== 10'd0) begin
      failures++; $display("FAIL write_through: got hit=%0d addr=%0d want 1/0", h, a);
    end
    write_pos(1'b0, 400, 400, 1'b1, 1'b0);
    drive_pixel(10, 10, 1'b1, a, sv, h);
    checks++;
    if (h !== 1'b1) begin failures++; $display("FAIL tear_free: got %0d want 1", h); end
    drive_pixel(400, 400, 1'b1, a, sv, h);
    checks++;
    if (h !== 1'b0) begin failures++; $display("FAIL shadow_leak: got %0d want 0", h); end
    frame();
    drive_pixel(10, 10, 1'b1, a, sv, h);
    checks++;
    if (h !== 1'b0) begin failures++; $display("FAIL old_pos_after_commit: got %0d want 0", h); end
    drive_pixel(403, 401, 1'b1, a, sv, h);
    checks++;
    if (h !== 1'b1 || a !== 10'd35) begin
      failures++; $display("FAIL new_pos_after_commit: got hit=%0d addr=%0d want 1/35", h, a);
    end
  endtask

  task automatic test_gating();
    logic [9:0] a; logic [0:0] sv; logic h;
    write_pos(1'b0, 0, 0, 1'b0, 1'b1);
    drive_pixel(0, 0, 1'b1, a, sv, h);
    checks++;
    if (h !== 1'b0) begin failures++; $display("FAIL disabled_sprite: got %0d want 0", h); end
    write_pos(1'b0, 0, 0, 1'b1, 1'b1);
    drive_pixel(0, 0, 1'b0, a, sv, h);
    checks++;
    if (h !== 1'b0 || a !== 10'd0) begin
      failures++; $display("FAIL video_off: got hit=%0d addr=%0d want 0/0", h, a);
    end
    drive_pixel(0, 0, 1'b1, a, sv, h);
    checks++;
    if (h !== 1'b1) begin failures++; $display("FAIL video_on_hit: got %0d want 1", h); end
  endtask

  task automatic test_mid_reset();
    logic [9:0] a; logic [0:0] sv; logic h;
    write_pos(1'b0, 50, 50, 1'b1, 1'b1);
    write_pos(1'b0, 60, 60, 1'b1, 1'b0);
    drive_pixel(50, 50, 1'b1, a, sv, h);
    checks++;
    if (h !== 1'b1) begin failures++; $display("FAIL pre_reset_hit: got %0d want 1", h); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (hit !== 1'b0 || rom_addr !== 10'd0) begin
      failures++; $display("FAIL mid_reset_clear: got hit=%0d addr=%0d want 0/0", hit, rom_addr);
    end
    rst = 1'b0;
    frame();
    drive_pixel(60, 60, 1'b1, a, sv, h);
    checks++;
    if (h !== 1'b0) begin failures++; $display("FAIL pending_discarded: got %0d want 0", h); end
    drive_pixel(0, 0, 1'b1, a, sv, h);
    checks++;
    if (h !== 1'b0) begin failures++; $display("FAIL reset_active_en: got %0d want 0", h); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; pixel_x = '0; pixel_y = '0; video_on = 1'b0; frame_start = 1'b0;
    pos_wr = 1'b0; pos_idx = '0; pos_x = '0; pos_y = '0; pos_en = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_commit();
    test_overlap();
    test_edge_clip();
    test_collision();
    test_gating();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_selector.md
Name: sprite_selector

Overview:
- Drives the select line and ROM read address for the sprite colour multiplexer in the VGA pipeline.
- Takes the current pixel coordinate from VGA timing and compares it against per-sprite screen positions.
- Outputs the winning sprite index, its ROM address, and a hit flag. `s` and `hit` are delayed to line up with the synchronous ROM read data.
- Sprite positions are double-buffered and committed at frame start, so sprites never tear mid-frame.

Parameters:
- M, 2, number of sprites (ROMs feeding the mux).
- B, $clog2(M), select bus width.
- SPR_W, 32, sprite width in pixels; must be a power of two.
- SPR_H, 32, sprite height in pixels.
- AW, $clog2(SPR_W*SPR_H), ROM address width.

Ports:
- clk  input  1  pixel clock
- rst  input  1  synchronous, active-high reset
- pixel_x  input  10  current horizontal pixel (0..639)
- pixel_y  input  10  current vertical pixel (0..479)
- video_on  input  1  high in the visible region
- frame_start  input  1  one-cycle pulse at start of each frame; commits shadow positions
- pos_wr  input  1  write strobe for a sprite position/enable
- pos_idx  input  B  sprite being written
- pos_x  input  10  new left edge
- pos_y  input  10  new top edge
- pos_en  input  1  new enable for the sprite
- rom_addr  output  AW  address to all sprite ROMs (registered, stage 1)
- s  output  B  mux select, aligned with ROM data (stage 2)
- hit  output  1  high when some enabled sprite covers the pixel (stage 2)

Behaviour:
- Reset:
  - All shadow and active x/y/en registers are 0.
  - Pipeline registers are 0, so `rom_addr`=0, `s`=0 and `hit`=0 on the cycle after `rst`.
- Reset mid-frame discards pending shadow writes and clears `hit` immediately at the next edge.
- Position write:
  - When `pos_wr`=1, shadow[`pos_idx`] takes `pos_x`, `pos_y` and `pos_en` at the clock edge.
  - `pos_idx` ≥ M is ignored.
  - Writes are always accepted; no backpressure.
- Commit:
  - When `frame_start`=1, active ← shadow for all sprites.
  - If `pos_wr` occurs in the same cycle, the committed value for that index is the newly written one (write-through).
  - Active registers change only on `frame_start`.
- Hit test (combinational, stage 0), per sprite i:
  - in_i = en_i & video_on & (pixel_x ≥ x_i) & ({1'b0,pixel_x} < {1'b0,x_i}+SPR_W) & (pixel_y ≥ y_i) & ({1'b0,pixel_y} < {1'b0,y_i}+SPR_H).
  - Comparisons use 11-bit sums, so a sprite at x=630 is clipped at the screen edge and never wraps to x=0.
- Priority: the lowest index with in_i=1 wins (sprite 0 is on top).
- Stage 1 (registered, 1-cycle latency):
  - `rom_addr` = ((pixel_y − y_win) * SPR_W) + (pixel_x − x_win), formed as a concatenation because SPR_W is a power of two.
  - An internal hit and winning index are registered alongside.
  - With no hit, `rom_addr`=0.
- Stage 2 (registered, 2-cycle latency from the pixel):
  - `s` and `hit` take the stage 1 values, matching the 1-cycle synchronous ROM read.
  - With `hit`=0, `s`=0.
- Overlap: when several sprites cover the same pixel, the lowest index wins. Equal positions resolve the same way.
- Disabled sprites never produce a hit, regardless of position.
- `video_on` low forces a miss, including when `pixel_x`/`pixel_y` still lie inside a sprite rectangle.

Test Plan:
- Reset: assert `rst` for 2 cycles with arbitrary inputs → `rom_addr`=0, `s`=0, `hit`=0. Write sprite 0 at (100,50) with `en`=1 and no `frame_start` → no hit at pixel (100,50).
- Commit and addressing: write sprite 1 at (200,100), `en`=1, then pulse `frame_start`. Drive pixel (205,103) → `rom_addr`=3*32+5=101 one cycle later; `s`=1 and `hit`=1 two cycles later. Pixel (232,103) → `hit`=0.
- Overlap: sprite 0 at (300,300) and sprite 1 at (310,310), both enabled. Pixel (315,315) → `s`=0 with `rom_addr`=15*32+15=495. Pixel (335,335) → `s`=1 with `rom_addr`=25*32+25=825.
- Edge clipping: sprite 0 at (630,470). Pixel (639,479) → `hit`=1, `rom_addr`=9*32+9=297. Pixel (0,470) → `hit`=0 (no wrap).
- Write/commit collision and tear-free update:
  - `pos_wr` for sprite 0 → (10,10) in the same cycle as `frame_start`; pixel (10,10) next frame → `hit`=1, `rom_addr`=0.
  - A mid-frame write of sprite 0 → (400,400) leaves pixel (10,10) still hitting until the next `frame_start`.
- `video_on`/enable gating: sprite at (0,0) with `en`=0 → no hit at (0,0). With `en`=1 but `video_on`=0 → `hit`=0.
